// File: rtl/run_controller.sv
// rtl/run_controller.sv - run-control sequencer: load imem/dmem, run core, detect ebreak/timeout, drain, dump dmem
module run_controller #(
  parameter int          ADDR_WIDTH     = 11,
  parameter logic [31:0] EBREAK_INST    = 32'h0010_0073,
  parameter int          DRAIN_CYCLES   = 5,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter int          DUMP_WORDS     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  load_sel,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  core_reset,
  input  logic [31:0]           inst_from_imem,
  output logic                  mem_we,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [31:0]           dump_addr,
  output logic [31:0]           dump_data,
  output logic [31:0]           run_cycles,
  output logic                  timeout,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;          // RUN cycle counter, reused as DRAIN counter
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;          // dump word index
  logic [31:0]           run_cycles_q, run_cycles_d;
  logic                  timeout_q, timeout_d;
  logic                  rd_last_q;             // previous cycle was DUMP_RD: mem_rdata is fresh
  logic [31:0]           hold_q;                // dump word held while the host stalls

  assign run_cycles = run_cycles_q;
  assign timeout    = timeout_q;
  assign dump_addr  = {{(30-ADDR_WIDTH){1'b0}}, idx_q, 2'b00};
  assign dump_data  = rd_last_q ? mem_rdata : hold_q;

  // Next-state and output decode; everything defaults to the inactive/holding value.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;
    load_ready   = 1'b0;
    core_reset   = 1'b1;
    mem_we       = 1'b0;
    mem_sel      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    dump_valid   = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_ready = 1'b1;
        cnt_d      = '0;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_sel   = load_sel;
          mem_addr  = load_addr;
          mem_wdata = load_data;
        end
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        core_reset = 1'b0;
        cnt_d      = cnt_q + 32'd1;
        if (inst_from_imem == EBREAK_INST) begin
          // ebreak takes priority over a timeout in the same cycle
          run_cycles_d = cnt_q;
          cnt_d        = '0;
          state_d      = S_DRAIN;
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          run_cycles_d = 32'(TIMEOUT_CYCLES);
          timeout_d    = 1'b1;
          state_d      = S_DUMP_RD;
        end
      end
      S_DRAIN: begin
        core_reset = 1'b0;
        cnt_d      = cnt_q + 32'd1;
        if (cnt_q >= 32'(DRAIN_CYCLES - 1)) state_d = S_DUMP_RD;
      end
      S_DUMP_RD: begin
        mem_sel  = 1'b1;
        mem_addr = idx_q;
        state_d  = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        // keep addressing the same word so a stall cannot disturb the read port
        mem_sel    = 1'b1;
        mem_addr   = idx_q;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == ADDR_WIDTH'(DUMP_WORDS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_DUMP_RD;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          idx_d     = '0;
          timeout_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      run_cycles_q <= '0;
      timeout_q    <= 1'b0;
      rd_last_q    <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
      rd_last_q    <= (state_q == S_DUMP_RD);
      if (rd_last_q) hold_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - self-checking bench for run_controller
module tb_run_controller;
  localparam int          AW     = 11;
  localparam int          TO     = 100;
  localparam int          DRAIN  = 5;
  localparam int          DW     = 20;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic          clk, reset, start, load_valid, load_ready, load_sel;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data, inst_from_imem, mem_wdata, mem_rdata;
  logic          core_reset, mem_we, mem_sel, dump_valid, dump_ready, timeout, done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   dump_addr, dump_data, run_cycles;

  run_controller #(.ADDR_WIDTH(AW), .EBREAK_INST(EBREAK), .DRAIN_CYCLES(DRAIN),
                   .TIMEOUT_CYCLES(TO), .DUMP_WORDS(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data),
    .core_reset(core_reset), .inst_from_imem(inst_from_imem),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .run_cycles(run_cycles), .timeout(timeout), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memories: imem/dmem with 1-cycle synchronous dmem read.
  logic [31:0] imem [0:2047];
  logic [31:0] dmem [0:2047];
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_sel) dmem[mem_addr] <= mem_wdata;
      else         imem[mem_addr] <= mem_wdata;
    end
    if (mem_sel) mem_rdata <= dmem[mem_addr];
  end

  // Reference view of dmem, updated only from what the host asked to load.
  logic [31:0] ref_dmem [0:2047];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input bit sel, input int addr, input logic [31:0] data);
    load_valid = 1'b1;
    load_sel   = sel;
    load_addr  = AW'(addr);
    load_data  = data;
    #1;
    chk("load_we", mem_we, 1);
    chk("load_sel", mem_sel, sel);
    chk("load_addr", mem_addr, AW'(addr));
    chk("load_wdata", mem_wdata, data);
    chk("load_ready", load_ready, 1);
    tick();
    load_valid = 1'b0;
    if (sel) ref_dmem[addr] = data;
    #1;
    chk("load_we_off", mem_we, 0);
  endtask

  // eb_at < 0 means no ebreak; abort_word >= 0 asserts reset while that word is offered.
  task automatic run_and_dump(input int eb_at, input int abort_word, input int stall_word);
    bit exp_to;
    int exp_rc;
    int guard;
    int s;
    exp_to = !(eb_at >= 0 && eb_at < TO);
    exp_rc = exp_to ? TO : eb_at;
    start = 1'b1;
    #1;
    if (load_valid) chk("we_with_start", mem_we, 1);
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    chk("core_reset_run", core_reset, 0);
    for (int n = 0; n < TO; n++) begin
      inst_from_imem = (n == eb_at) ? EBREAK : NOP;
      if (n == 10) begin
        load_valid = 1'b1; load_sel = 1'b1; load_addr = AW'(5); load_data = $urandom;
        #1;
        chk("run_load_we", mem_we, 0);
        chk("run_load_ready", load_ready, 0);
      end
      tick();
      load_valid = 1'b0;
      if (n == eb_at) break;
    end
    inst_from_imem = EBREAK;
    if (!exp_to) begin
      for (int d = 0; d < DRAIN; d++) begin
        chk("core_reset_drain", core_reset, 0);
        tick();
      end
    end
    inst_from_imem = NOP;
    chk("core_reset_dump", core_reset, 1);
    chk("run_cycles", run_cycles, 32'(exp_rc));
    chk("timeout", timeout, exp_to);
    chk("dump_rd_valid", dump_valid, 0);
    for (int i = 0; i < DW; i++) begin
      guard = 0;
      while (dump_valid !== 1'b1 && guard < 8) begin tick(); guard++; end
      chk("dump_valid", dump_valid, 1);
      chk("dump_addr", dump_addr, 32'(4 * i));
      chk("dump_data", dump_data, ref_dmem[i]);
      if (i == abort_word) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", dump_valid, 0);
        chk("abort_core_reset", core_reset, 1);
        chk("abort_load_ready", load_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_timeout", timeout, 0);
        chk("abort_run_cycles", run_cycles, 0);
        return;
      end
      s = (i == stall_word) ? 3 : int'($urandom_range(0, 1));
      repeat (s) begin
        tick();
        chk("stall_valid", dump_valid, 1);
        chk("stall_addr", dump_addr, 32'(4 * i));
        chk("stall_data", dump_data, ref_dmem[i]);
      end
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
      if (i < DW - 1) chk("dump_gap", dump_valid, 0);
    end
    chk("done", done, 1);
    chk("done_valid", dump_valid, 0);
    tick();
    tick();
    chk("done_hold", done, 1);
    chk("done_timeout_hold", timeout, exp_to);
    chk("done_rc_hold", run_cycles, 32'(exp_rc));
  endtask

  task automatic leave_done();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_timeout", timeout, 0);
    chk("idle_load_ready", load_ready, 1);
    chk("idle_core_reset", core_reset, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2048; k++) begin imem[k] = '0; dmem[k] = '0; ref_dmem[k] = '0; end
    reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_sel = 1'b0;
    load_addr = '0; load_data = '0; inst_from_imem = NOP; dump_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_run_cycles", run_cycles, 0);

    // Run 1: directed loads, ebreak at 37, stall on word 2, load alongside start.
    for (int k = 0; k < DW; k++) load(1'b1, k, $urandom);
    load(1'b0, 20, 32'h0000_0013);
    load(1'b1, 3, 32'hDEAD_BEEF);
    chk("imem20", imem[20], 32'h0000_0013);
    load_valid = 1'b1; load_sel = 1'b1; load_addr = AW'(19); load_data = $urandom;
    ref_dmem[19] = load_data;
    run_and_dump(37, -1, 2);
    leave_done();

    // Run 2: timeout with no ebreak.
    for (int k = 0; k < 4; k++) load(1'b1, $urandom_range(0, DW - 1), $urandom);
    run_and_dump(-1, -1, 5);
    leave_done();

    // Run 3: ebreak in the timeout cycle, then reset mid-dump at word 7.
    run_and_dump(TO - 1, 7, -1);

    // Run 4: fresh run after the abort dumps from word 0 with a random ebreak point.
    load(1'b1, 0, $urandom);
    run_and_dump(int'($urandom_range(1, 90)), -1, 11);
    leave_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
